// File: rtl/chacha_xor_stream.sv
// chacha_xor_stream: XORs payload bytes with keystream bytes pulled from the
// ChaCha block core, tracking position within each 64-byte block and waiting
// through the core's refill between blocks.
// Optional macro CHACHA_XOR_DISCARD_EN: on in_last, drain the rest of the
// current block so the next message starts on a fresh block.
`timescale 1ns/1ps

module chacha_xor_stream #(
    parameter int unsigned BLK_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    input  logic [7:0]           ks_data,
    input  logic                 ks_ready,
    output logic                 ks_read,
    output logic [5:0]           byte_idx,
    output logic [BLK_CNT_W-1:0] blk_count
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 6;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(63);

    typedef enum logic [1:0] {
        ST_STREAM    = 2'd0,
        ST_REFILL_LO = 2'd1,
        ST_REFILL_HI = 2'd2
`ifdef CHACHA_XOR_DISCARD_EN
        , ST_DRAIN   = 2'd3
`endif
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_W-1:0]     r_out_data;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [IDX_W-1:0]      r_byte_idx;
    logic [BLK_CNT_W-1:0]  r_blk_count;

    logic                  w_out_free;
    logic                  w_in_ready;
    logic                  w_xfer;
    logic                  w_drain_rd;
    logic                  w_advance;
    logic                  w_blk_end;

    // Handshake and keystream-advance qualifiers
    assign w_out_free = ~r_out_valid | out_ready;
    assign w_in_ready = (r_state == ST_STREAM) & ks_ready & w_out_free;
    assign w_xfer     = in_valid & w_in_ready;
`ifdef CHACHA_XOR_DISCARD_EN
    assign w_drain_rd = (r_state == ST_DRAIN) & ks_ready;
`else
    assign w_drain_rd = 1'b0;
`endif
    assign w_advance  = w_xfer | w_drain_rd;
    assign w_blk_end  = w_advance & (r_byte_idx == LAST_IDX);

    assign in_ready  = w_in_ready;
    assign ks_read   = w_advance & ~rst;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign byte_idx  = r_byte_idx;
    assign blk_count = r_blk_count;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_STREAM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: stream, then wait for ready to fall and rise across a refill
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_STREAM: begin
                if (w_blk_end) begin
                    w_state_nxt = ST_REFILL_LO;
                end
`ifdef CHACHA_XOR_DISCARD_EN
                else if (w_xfer & in_last) begin
                    w_state_nxt = ST_DRAIN;
                end
`endif
            end
            ST_REFILL_LO: begin
                if (!ks_ready) begin
                    w_state_nxt = ST_REFILL_HI;
                end
            end
            ST_REFILL_HI: begin
                if (ks_ready) begin
                    w_state_nxt = ST_STREAM;
                end
            end
`ifdef CHACHA_XOR_DISCARD_EN
            ST_DRAIN: begin
                if (w_blk_end) begin
                    w_state_nxt = ST_REFILL_LO;
                end
            end
`endif
            default: w_state_nxt = ST_STREAM;
        endcase
    end

    // Output register: load on transfer, otherwise clear once drained
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_xfer) begin
            r_out_data  <= in_data ^ ks_data;
            r_out_valid <= 1'b1;
            r_out_last  <= in_last;
        end else if (out_ready & r_out_valid) begin
            r_out_valid <= 1'b0;
        end
    end

    // Keystream position and consumed-block counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_idx  <= '0;
            r_blk_count <= '0;
        end else begin
            if (w_advance) begin
                r_byte_idx <= r_byte_idx + IDX_W'(1);
            end
            if (w_blk_end) begin
                r_blk_count <= r_blk_count + BLK_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_chacha_xor_stream.sv
// Testbench for chacha_xor_stream with a behavioural keystream core model and
// an expected-output queue.
`timescale 1ns/1ps

module tb_chacha_xor_stream;

    localparam int unsigned BLK_CNT_W = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [7:0]           in_data = 8'h00;
    logic                 in_valid = 1'b0;
    logic                 in_last = 1'b0;
    logic                 in_ready;
    logic [7:0]           out_data;
    logic                 out_valid;
    logic                 out_last;
    logic                 out_ready = 1'b1;
    logic [7:0]           ks_data;
    logic                 ks_ready;
    logic                 ks_read;
    logic [5:0]           byte_idx;
    logic [BLK_CNT_W-1:0] blk_count;

    int vectors = 0;
    int miscompares = 0;

    chacha_xor_stream #(.BLK_CNT_W(BLK_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .ks_data(ks_data), .ks_ready(ks_ready), .ks_read(ks_read),
        .byte_idx(byte_idx), .blk_count(blk_count)
    );

    always #5 clk = ~clk;

    // Keystream byte for a given block number and address
    function automatic logic [7:0] ksf(input int unsigned blk, input int unsigned addr);
        logic [7:0] a;
        logic [7:0] b;
        a = 8'(addr * 32'd29);
        b = 8'(blk * 32'd113);
        return 8'h0F ^ a ^ b;
    endfunction

    // ---------------- core model ----------------
    int unsigned core_blk = 0;
    int unsigned core_addr = 0;
    logic        core_rdy = 1'b1;
    int unsigned core_phase = 0;   // 0 ready, 1 stale-ready, 2 refilling
    int unsigned core_cnt = 0;
    int unsigned stale_cyc = 0;
    int unsigned low_cyc = 3;
    int unsigned rd_total = 0;
    int unsigned blk_reads = 0;
    int unsigned last_blk_reads = 0;
    logic        ks_gate = 1'b0;
    int unsigned cyc = 0;

    assign ks_ready = core_rdy & ~ks_gate;
    assign ks_data  = ksf(core_blk, core_addr);

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) begin
            core_blk   <= 0;
            core_addr  <= 0;
            core_rdy   <= 1'b1;
            core_phase <= 0;
            core_cnt   <= 0;
            blk_reads  <= 0;
        end else begin
            if (ks_read) begin
                rd_total = rd_total + 1;
                vectors++;
                if (core_phase != 0 || ks_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ks_read_guard: ks_read=1 with core_phase=%0d ks_ready=%b, required no read", core_phase, ks_ready);
                end
            end
            case (core_phase)
                0: if (ks_read) begin
                    if (core_addr == 63) begin
                        core_phase     <= 1;
                        core_cnt       <= stale_cyc;
                        last_blk_reads <= blk_reads + 1;
                        blk_reads      <= 0;
                    end else begin
                        core_addr <= core_addr + 1;
                        blk_reads <= blk_reads + 1;
                    end
                end
                1: if (core_cnt == 0) begin
                    core_rdy   <= 1'b0;
                    core_phase <= 2;
                    core_cnt   <= low_cyc - 1;
                end else begin
                    core_cnt <= core_cnt - 1;
                end
                default: if (core_cnt == 0) begin
                    core_rdy   <= 1'b1;
                    core_phase <= 0;
                    core_blk   <= core_blk + 1;
                    core_addr  <= 0;
                end else begin
                    core_cnt <= core_cnt - 1;
                end
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int unsigned sb_pos = 0;
    int unsigned acc_cyc = 0;
    int unsigned acc_rd = 0;
    logic        bp_rand = 1'b0;

    task automatic push_expected(input logic [7:0] d, input logic l);
        exp_t e;
        int unsigned blk;
        int unsigned idx;
        blk = sb_pos / 64;
        idx = sb_pos % 64;
        e.d = d ^ ksf(blk, idx);
        e.l = l;
        sb_q.push_back(e);
        sb_pos = sb_pos + 1;
`ifdef CHACHA_XOR_DISCARD_EN
        if (l && idx != 63) sb_pos = (blk + 1) * 64;
`endif
    endtask

    // Output monitor: compare every handshaked byte against the queue head
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL out_unexpected: got out_data=%h with nothing expected", out_data);
            end else begin
                mon_e = sb_q.pop_front();
                if (out_data !== mon_e.d || out_last !== mon_e.l) begin
                    miscompares++;
                    $display("FAIL out_byte: got %h last=%b, required %h last=%b", out_data, out_last, mon_e.d, mon_e.l);
                end
            end
        end
    end

    // Random downstream backpressure
    always @(posedge clk) begin
        #1;
        if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] d, input logic l);
        bit done;
        done = 1'b0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                push_expected(d, l);
                acc_cyc = cyc;
                acc_rd  = rd_total;
                done    = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL send_timeout: byte %h not accepted in 300 cycles, required acceptance", d);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d outputs pending, required 0", sb_q.size());
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        ks_gate  = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        sb_pos = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (ks_read !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_ks_read: got %b, required 0", ks_read);
            end
            @(posedge clk);
        end
        #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out: got valid=%b data=%h last=%b, required 0/00/0", out_valid, out_data, out_last);
        end
        vectors++;
        if (byte_idx !== 6'd0 || blk_count !== '0) begin
            miscompares++;
            $display("FAIL reset_counters: got byte_idx=%0d blk_count=%0d, required 0/0", byte_idx, blk_count);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_byte();
        out_ready = 1'b1;
        in_data = 8'h5A; in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if (ks_read !== 1'b1 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_ks_read: got ks_read=%b in_ready=%b, required 1/1", ks_read, in_ready);
        end
        push_expected(8'h5A, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h55 || byte_idx !== 6'd1) begin
            miscompares++;
            $display("FAIL single_out: got valid=%b data=%h idx=%0d, required 1/55/1", out_valid, out_data, byte_idx);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        in_data = 8'hC3; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0 || ks_read !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h55) begin
                miscompares++;
                $display("FAIL bp_hold: got in_ready=%b ks_read=%b valid=%b data=%h, required 0/0/1/55", in_ready, ks_read, out_valid, out_data);
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send_byte(8'hC3, 1'b0);
        vectors++;
        if (byte_idx !== 6'd2) begin
            miscompares++;
            $display("FAIL bp_idx: got byte_idx=%0d, required 2", byte_idx);
        end
    endtask

    task automatic stream_block(output int unsigned first_c, output int unsigned last_c);
        first_c = 0;
        for (int i = 0; i < 64; i++) begin
            send_byte(8'(i * 3 + 1), 1'b0);
            if (i == 0) first_c = acc_cyc;
        end
        last_c = acc_cyc;
    endtask

    task automatic test_block_boundary();
        int unsigned c_first;
        int unsigned c_last;
        wait_drain();
        stale_cyc = 0; low_cyc = 3;
        do_reset();
        stream_block(c_first, c_last);
        vectors++;
        if (c_last - c_first != 63) begin
            miscompares++;
            $display("FAIL blk_throughput: got %0d cycles for 64 bytes, required 63", c_last - c_first);
        end
        send_byte(8'hA7, 1'b0);
        vectors++;
        if (acc_cyc - c_last != 6) begin
            miscompares++;
            $display("FAIL blk_refill_gap: got %0d cycles, required 6", acc_cyc - c_last);
        end
        vectors++;
        if (blk_count !== 16'd1 || byte_idx !== 6'd1 || last_blk_reads != 64) begin
            miscompares++;
            $display("FAIL blk_counts: got blk_count=%0d idx=%0d reads=%0d, required 1/1/64", blk_count, byte_idx, last_blk_reads);
        end
    endtask

    task automatic test_stale_ready();
        int unsigned c_first;
        int unsigned c_last;
        wait_drain();
        stale_cyc = 2; low_cyc = 3;
        do_reset();
        stream_block(c_first, c_last);
        in_data = 8'h9E; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0 || ks_read !== 1'b0) begin
                miscompares++;
                $display("FAIL stale_hold: got in_ready=%b ks_read=%b, required 0/0", in_ready, ks_read);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        send_byte(8'h9E, 1'b0);
        vectors++;
        if (acc_cyc - c_last != 8) begin
            miscompares++;
            $display("FAIL stale_gap: got %0d cycles, required 8", acc_cyc - c_last);
        end
        stale_cyc = 0;
    endtask

    task automatic test_ks_hold();
        ks_gate = 1'b1;
        in_data = 8'h3C; in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0 || ks_read !== 1'b0) begin
                miscompares++;
                $display("FAIL ks_hold: got in_ready=%b ks_read=%b, required 0/0", in_ready, ks_read);
            end
            @(posedge clk);
            #1;
        end
        ks_gate = 1'b0; in_valid = 1'b0;
        send_byte(8'h3C, 1'b0);
        vectors++;
        if (byte_idx !== 6'd2) begin
            miscompares++;
            $display("FAIL ks_hold_idx: got byte_idx=%0d, required 2", byte_idx);
        end
    endtask

    task automatic test_last();
        int unsigned r0;
        wait_drain();
        do_reset();
        for (int i = 0; i < 10; i++) send_byte(8'(8'h40 + i), (i == 9));
        r0 = acc_rd;
        send_byte(8'hE1, 1'b0);
`ifdef CHACHA_XOR_DISCARD_EN
        vectors++;
        if (acc_rd - r0 != 55 || blk_count !== 16'd1 || byte_idx !== 6'd1) begin
            miscompares++;
            $display("FAIL discard: got reads=%0d blk_count=%0d idx=%0d, required 55/1/1", acc_rd - r0, blk_count, byte_idx);
        end
`else
        vectors++;
        if (acc_rd - r0 != 1 || blk_count !== 16'd0 || byte_idx !== 6'd11) begin
            miscompares++;
            $display("FAIL last_passthru: got reads=%0d blk_count=%0d idx=%0d, required 1/0/11", acc_rd - r0, blk_count, byte_idx);
        end
`endif
    endtask

    task automatic test_back_to_back();
        wait_drain();
        do_reset();
        bp_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send_byte(8'($urandom), ($urandom_range(0, 39) == 0));
        end
        bp_rand = 1'b0;
        wait_drain();
        vectors++;
        if (blk_count == '0) begin
            miscompares++;
            $display("FAIL b2b_blocks: got blk_count=0, required nonzero after 150 bytes");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_backpressure();
        test_block_boundary();
        test_stale_ready();
        test_ks_hold();
        test_last();
        test_back_to_back();
        wait_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/chacha_xor_stream.md
Name: chacha_xor_stream

Overview:
- Downstream consumer of the ChaCha block core's keystream byte port.
- Pulls one keystream byte per accepted payload byte and XORs the two.
- Presents the result on a registered valid/ready output.
- Tracks the byte position within the 64-byte keystream block and waits through the core's refill between blocks; sits between the core and the chip I/O byte stream.

Parameters:
- BLK_CNT_W, default 16: width of the consumed-block counter output.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_data  input  8  plaintext/ciphertext byte.
- in_valid  input  1  in_data valid.
- in_last  input  1  byte is last of message; qualified by in_valid.
- in_ready  output  1  stage accepts in_data this cycle.
- out_data  output  8  in_data XOR keystream byte, registered.
- out_valid  output  1  out_data valid.
- out_last  output  1  registered copy of in_last.
- out_ready  input  1  downstream accepts out_data.
- ks_data  input  8  keystream byte at the core's current read address.
- ks_ready  input  1  core holds a finished block (core ready).
- ks_read  output  1  one-cycle pulse advancing the core read address by one.
- byte_idx  output  6  index of next keystream byte in current block.
- blk_count  output  BLK_CNT_W  keystream blocks fully consumed since reset; wraps.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=STREAM; byte_idx=0; blk_count=0.
  - out_valid=0, out_data=0, out_last=0; ks_read=0.
  - Reset mid-block abandons the block; the core is reset separately by the system.
- States:
  - STREAM: consuming bytes.
  - REFILL_LO: waiting for ks_ready to fall.
  - REFILL_HI: waiting for ks_ready to rise.
  - DRAIN: only with the optional feature.
- Output register:
  - out_free = !out_valid | out_ready.
  - in_ready = (state==STREAM) & ks_ready & out_free (combinational).
  - xfer = in_valid & in_ready.
  - ks_read = xfer & !rst (combinational, same cycle as xfer). ks_data is sampled in that cycle.
- On xfer:
  - out_data <= in_data ^ ks_data; out_last <= in_last; out_valid <= 1.
  - byte_idx <= byte_idx+1, 6-bit wrap.
- If out_ready & out_valid & !xfer: out_valid <= 0.
- Simultaneous drain and fill (out_ready=1 with out_valid=1 and xfer=1): the new byte replaces the old with no bubble. Full throughput is 1 byte/clk.
- Block boundary: on xfer with byte_idx==63:
  - byte_idx <= 0; blk_count <= blk_count+1 (wraps); state <= REFILL_LO.
  - REFILL_LO: in_ready=0; go to REFILL_HI when ks_ready==0. This ignores stale ready during the core's done/increment transition.
  - REFILL_HI: in_ready=0; go to STREAM when ks_ready==1. Earliest next xfer is the cycle after entering STREAM.
- If ks_ready stays low in STREAM: in_valid is held off (in_ready=0). No data is lost and no ks_read is issued.
- out_valid/out_data/out_last hold stable while out_valid=1 & out_ready=0 (standard valid/ready; no retraction).
- in_last has no effect on state without the optional feature. Leftover keystream continues into the next message.

Optional Feature:
- Macro: CHACHA_XOR_DISCARD_EN.
- Defined: on xfer with in_last=1 and byte_idx!=63:
  - state <= DRAIN.
  - DRAIN: in_ready=0; ks_read=1 each cycle while ks_ready=1; byte_idx increments per pulse.
  - After the pulse at byte_idx==63: byte_idx <= 0, blk_count+1, state <= REFILL_LO.
  - The next message always starts at keystream byte 0 of a fresh block.
  - in_last at byte_idx==63 follows the normal boundary path.
- Undefined: DRAIN state absent; in_last is only passed through to out_last.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1, ks_ready=1 -> out_valid=0, ks_read=0, byte_idx=0, blk_count=0, in_ready=1 on the first cycle after rst falls.
- Single byte: in_data=0x5A, ks_data=0x0F, ks_ready=1, out_ready=1 -> ks_read pulse that cycle; next cycle out_data=0x55, out_valid=1, byte_idx=1.
- Backpressure: out_ready=0 after first byte; present second byte -> in_ready=0, ks_read=0, out_data held at 0x55 until out_ready=1.
- Block boundary: stream 64 bytes at 1/clk; model drops ks_ready for 3 cycles then raises -> exactly 64 ks_read pulses; blk_count=1; no xfer until the cycle after ks_ready returns; byte 65 uses new ks_data.
- Stale ready: hold ks_ready=1 for 2 cycles after byte 63 before dropping -> stage stays in REFILL_LO, no ks_read, in_ready=0.
- Discard (CHACHA_XOR_DISCARD_EN): 10-byte message, in_last on byte 10 -> 54 further ks_read pulses with in_ready=0; blk_count=1; next message byte uses byte_idx 0. Without the macro: next byte uses byte_idx 10.
